// File: rtl/booth_pkg.sv
// Shared constants for the sequential Booth multiplier: FSM encodings and
// the two Booth recoding patterns that trigger an add or a subtract.
package booth_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_mult_seq_addsub.sv
// Ripple-carry add/sub: S = A + (B ^ {W{M}}) + M, so M=1 subtracts B.
// C is the final carry-out, and V is signed overflow (the carry into the MSB XOR the carry out of it).
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module addsub_nbit #(
   parameter int W = 5
) (
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         M,
   output logic [W-1:0] S,
   output logic         V,
   output logic         C
);
   logic [W:0] carry;

   assign carry[0] = M;

   for (genvar i = 0; i < W; i++) begin : g_bit
      full_adder u_fa (
         .a  (A[i]),
         .b  (B[i] ^ M),
         .ci (carry[i]),
         .s  (S[i]),
         .co (carry[i+1])
      );
   end

   assign C = carry[W];
   assign V = carry[W] ^ carry[W-1];
endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one add/sub-then-shift step per clock,
// 2*WIDTH signed product with a one-cycle done pulse.
module booth_mult_seq
   import booth_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [1:0]         state_q, state_d;
   logic [WIDTH:0]     a_q, a_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic               q1_q, q1_d;
   logic [WIDTH:0]     mx_q, mx_d;
   logic [CW-1:0]      count_q, count_d;
   logic [2*WIDTH-1:0] product_q, product_d;

   logic [1:0]         booth_code;
   logic               add_mode;
   logic [WIDTH:0]     add_sum;
   logic               add_v, add_c;
   logic               unused_addsub;
   logic [WIDTH:0]     a_sel;
   logic [2*WIDTH:0]   shifted;

   assign booth_code = {q_q[0], q1_q};
   assign add_mode   = (booth_code == BOOTH_SUB);

   // A is WIDTH+1 bits so that subtracting the most negative M cannot overflow
   addsub_nbit #(.W(WIDTH + 1)) u_addsub (
      .A (a_q),
      .B (mx_q),
      .M (add_mode),
      .S (add_sum),
      .V (add_v),
      .C (add_c)
   );

   assign unused_addsub = add_v ^ add_c;

   assign a_sel   = (booth_code == BOOTH_ADD || booth_code == BOOTH_SUB) ? add_sum : a_q;
   assign shifted = {a_sel[WIDTH], a_sel, q_q[WIDTH-1:1]};

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      q_d       = q_q;
      q1_d      = q1_q;
      mx_d      = mx_q;
      count_d   = count_q;
      product_d = product_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = '0;
               q_d     = multiplier;
               q1_d    = 1'b0;
               mx_d    = {multiplicand[WIDTH-1], multiplicand};
               count_d = CW'(WIDTH);
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            a_d     = shifted[2*WIDTH:WIDTH];
            q_d     = shifted[WIDTH-1:0];
            q1_d    = q_q[0];
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               product_d = shifted[2*WIDTH-1:0];
               state_d   = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         a_q       <= '0;
         q_q       <= '0;
         q1_q      <= 1'b0;
         mx_q      <= '0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         q_q       <= q_d;
         q1_q      <= q1_d;
         mx_q      <= mx_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   assign busy    = (state_q == ST_CALC);
   assign done    = (state_q == ST_DONE);
   assign product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq (WIDTH=4) against a signed-multiply reference model.
module tb_booth_mult_seq;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] multiplicand;
   logic [3:0] multiplier;
   logic       busy;
   logic       done;
   logic [7:0] product;

   int tests_run = 0;
   int fails     = 0;

   logic [7:0] exp_q[$];

   booth_mult_seq #(.WIDTH(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // reference model: plain signed multiplication
   function automatic logic [7:0] ref_mul(input logic [3:0] m, input logic [3:0] q);
      int a;
      int b;
      a = $signed(m);
      b = $signed(q);
      return 8'(a * b);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // driver + checks for one multiply; returns with DUT back in IDLE
   task automatic run_mult(input logic [3:0] m, input logic [3:0] q,
                           input logic [7:0] spec_exp, input bit use_spec, input string name);
      int lat;
      int busy_cnt;
      logic [7:0] exp;
      exp_q.push_back(ref_mul(m, q));
      start = 1'b1;
      multiplicand = m;
      multiplier = q;
      tick();
      start = 1'b0;
      multiplicand = 4'($urandom);
      multiplier = 4'($urandom);
      lat = 0;
      busy_cnt = 0;
      while (!done && lat < 20) begin
         if (busy) busy_cnt++;
         tick();
         lat++;
      end
      exp = exp_q.pop_front();
      tests_run++;
      if (lat !== 4) begin
         fails++;
         $display("FAIL %s latency: got %0d expected 4", name, lat);
      end
      tests_run++;
      if (busy_cnt !== 4) begin
         fails++;
         $display("FAIL %s busy_cycles: got %0d expected 4", name, busy_cnt);
      end
      tests_run++;
      if (product !== exp) begin
         fails++;
         $display("FAIL %s product: got %h expected %h (M=%h Q=%h)", name, product, exp, m, q);
      end
      if (use_spec) begin
         tests_run++;
         if (product !== spec_exp) begin
            fails++;
            $display("FAIL %s product_const: got %h expected %h", name, product, spec_exp);
         end
      end
      tests_run++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL %s busy_in_done: got %b expected 0", name, busy);
      end
      tick();
      tests_run++;
      if (done !== 1'b0 || product !== exp) begin
         fails++;
         $display("FAIL %s after_done: done=%b product=%h expected done=0 product=%h",
                  name, done, product, exp);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      multiplicand = '0;
      multiplier = '0;
      repeat (3) tick();
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
         fails++;
         $display("FAIL reset: busy=%b done=%b product=%h expected 0 0 00", busy, done, product);
      end
      rst_n = 1'b1;
      tick();
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done);
      end
   endtask

   task automatic test_directed();
      run_mult(4'd3,  4'd5,  8'h0F, 1'b1, "m3_q5");
      run_mult(4'h8,  4'h8,  8'h40, 1'b1, "mneg8_qneg8");
      run_mult(4'd7,  4'h8,  8'hC8, 1'b1, "m7_qneg8");
      run_mult(4'hD,  4'd6,  8'hEE, 1'b1, "mneg3_q6");
      run_mult(4'd0,  4'hF,  8'h00, 1'b1, "m0_qneg1");
      run_mult(4'h7,  4'h7,  8'h31, 1'b1, "m7_q7");
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         run_mult(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 8'h00, 1'b0, "random");
      end
   endtask

   task automatic test_ignore_start();
      int done_cnt;
      int lat;
      start = 1'b1;
      multiplicand = 4'd3;
      multiplier = 4'd5;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      multiplicand = 4'd2;
      multiplier = 4'd2;
      tick();
      start = 1'b0;
      lat = 2;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      tests_run++;
      if (lat !== 4 || product !== ref_mul(4'd3, 4'd5)) begin
         fails++;
         $display("FAIL ignore_start product: got %h lat %0d expected %h lat 4",
                  product, lat, ref_mul(4'd3, 4'd5));
      end
      tests_run++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL ignore_start busy_in_done: got %b expected 0", busy);
      end
      done_cnt = 1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done) done_cnt++;
      end
      tests_run++;
      if (done_cnt !== 1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL ignore_start done_pulses: got %0d busy=%b expected 1 busy=0", done_cnt, busy);
      end
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      multiplicand = 4'hD;
      multiplier = 4'd6;
      tick();
      start = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
         fails++;
         $display("FAIL reset_mid async: busy=%b done=%b product=%h expected 0 0 00",
                  busy, done, product);
      end
      #2;
      rst_n = 1'b1;
      tick();
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
         fails++;
         $display("FAIL reset_mid after_release: busy=%b done=%b product=%h expected 0 0 00",
                  busy, done, product);
      end
      run_mult(4'd7, 4'h8, 8'hC8, 1'b1, "after_reset");
   endtask

   // start held high: accepted at edges 1, 7, 13, ...; done visible after edges 5, 11, ...
   task automatic test_back_to_back();
      logic [3:0] om[0:40];
      logic [3:0] oq[0:40];
      logic [7:0] last;
      logic [7:0] exp;
      int ph;
      last = ref_mul(4'd7, 4'h8);
      om[1] = 4'($urandom);
      oq[1] = 4'($urandom);
      start = 1'b1;
      multiplicand = om[1];
      multiplier = oq[1];
      for (int e = 1; e <= 30; e++) begin
         @(posedge clk);
         if ((e - 1) % 6 == 0) exp_q.push_back(ref_mul(om[e], oq[e]));
         #1;
         ph = (e - 1) % 6;
         tests_run++;
         if (busy !== (ph < 4) || done !== (ph == 4)) begin
            fails++;
            $display("FAIL back_to_back flags edge %0d: busy=%b done=%b expected %b %b",
                     e, busy, done, (ph < 4), (ph == 4));
         end
         if (ph == 4) begin
            exp = exp_q.pop_front();
            last = exp;
         end
         tests_run++;
         if (product !== last) begin
            fails++;
            $display("FAIL back_to_back product edge %0d: got %h expected %h", e, product, last);
         end
         om[e+1] = 4'($urandom);
         oq[e+1] = 4'($urandom);
         multiplicand = om[e+1];
         multiplier = oq[e+1];
      end
      start = 1'b0;
      repeat (8) tick();
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== last) begin
         fails++;
         $display("FAIL back_to_back drain: busy=%b done=%b product=%h expected 0 0 %h",
                  busy, done, product, last);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      tests_run++;
      if (exp_q.size() !== 0) begin
         fails++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
